s3g_rx_pkt: RTL and testbench

Parametrised S3G packet receiver that follows the UART byte stream (rx_data/rx_done) and frames packets as 0xD5, LEN, LEN payload bytes, then CRC8.
- Stores the payload in an internal buffer, checks the CRC and holds each good packet for the host.
- Adds length validation, a host acknowledge handshake, overrun detection and an optional inter-byte timeout.
- Sits between uart_transceiver and the command decoder.

---
 rtl/s3g_pkg.sv | 28 ++
 rtl/s3g_rx_ram.sv | 35 +++
 rtl/s3g_rx_pkt.sv | 168 ++++++++++++++++
 tb/tb_s3g_rx_pkt.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// s3g_pkg: shared definitions for the S3G packet receiver.
//   state_t        - receiver FSM state encoding (2 bits)
//   S3G_START      - default packet start marker
//   S3G_CRC_POLY   - reflected CRC8 polynomial (x^8+x^5+x^4+1)
//   crc8_d8()      - folds one byte into a running CRC8
package s3g_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CRC  = 2'd3
  } state_t;

  localparam logic [7:0] S3G_START    = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;

  // Reflected CRC8: the data byte is xored in first, then shifted out LSB first.
  function automatic logic [7:0] crc8_d8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_rx_ram.sv
// s3g_rx_ram: payload buffer, one write port and one registered read port.
//   clk      in   system clock
//   rst      in   synchronous active-high reset (read register only)
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], one cycle later
module s3g_rx_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[wr_addr] <= wr_data;
  end

  // Addresses beyond DEPTH keep the previous read value rather than reading
  // outside the array.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'd0;
    else if (32'(rd_addr) < DEPTH) rd_data <= r_mem[rd_addr];
  end

endmodule

// File: rtl/s3g_rx_pkt.sv
// s3g_rx_pkt: frames S3G packets (START, LEN, LEN payload bytes, CRC8) from
// the UART byte stream, buffers the payload and holds each good packet until
// the host acknowledges it.
// Optional build macro S3G_RX_TIMEOUT_EN: abort a packet after TIMEOUT_CYC
// idle clocks between bytes.
//   clk/rst        clock, synchronous active-high reset
//   rx_data/rx_done  received byte and its single-cycle strobe
//   buffer_addr    payload read address
//   buffer_data    payload byte, 1-cycle read latency
//   buffer_len     payload length of the held packet
//   buffer_valid   a good packet is held
//   packet_ack     host releases the held packet
//   packet_done    1-cycle pulse on a good packet
//   packet_error   1-cycle pulse on CRC, length or timeout error
//   overrun        sticky: START seen while a packet was held
module s3g_rx_pkt
  import s3g_pkg::*;
#(
  parameter int         MAX_LEN     = 32,
  parameter int         ADDR_W      = 5,
  parameter logic [7:0] START_BYTE  = S3G_START,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic [ADDR_W-1:0] buffer_addr,
  output logic [7:0]        buffer_data,
  output logic [7:0]        buffer_len,
  output logic              buffer_valid,
  input  logic              packet_ack,
  output logic              packet_done,
  output logic              packet_error,
  output logic              overrun
);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_len, r_byte_cnt, r_crc, r_buffer_len;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_buffer_valid, r_overrun, r_done, r_error;
  logic              w_ack, w_start, w_len_ok, w_len_ld, w_data_byte, w_wr_en;
  logic              w_accept, w_error, w_overrun_set, w_timeout;

  assign w_ack       = packet_ack & r_buffer_valid;
  assign w_start     = rx_done & (rx_data == START_BYTE);
  assign w_len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MAX_LEN);
  assign w_data_byte = rx_done & (r_state == S_DATA);
  // The held packet is never overwritten, even if the FSM were somehow in S_DATA.
  assign w_wr_en     = w_data_byte & ~r_buffer_valid;

`ifdef S3G_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || rx_done || r_state == S_IDLE) r_to_cnt <= '0;
    else if (r_to_cnt != TO_W'(TIMEOUT_CYC - 1)) r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_timeout = (r_state != S_IDLE) && !rx_done && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_len_ld      = 1'b0;
    w_accept      = 1'b0;
    w_error       = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        // An ack in the same cycle frees the buffer, so the new packet is taken.
        if (w_start) begin
          if (r_buffer_valid && !w_ack) w_overrun_set = 1'b1;
          else                          w_state_nxt   = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          if (w_len_ok) begin
            w_len_ld    = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_error     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx_done && r_byte_cnt == 8'd1) w_state_nxt = S_CRC;
      end
      S_CRC: begin
        if (rx_done) begin
          if (rx_data == r_crc) w_accept = 1'b1;
          else                  w_error  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_error     = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len          <= 8'd0;
      r_byte_cnt     <= 8'd0;
      r_crc          <= 8'd0;
      r_wr_ptr       <= '0;
      r_buffer_len   <= 8'd0;
      r_buffer_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_done  <= w_accept;
      r_error <= w_error;
      if (w_len_ld) begin
        r_len      <= rx_data;
        r_byte_cnt <= rx_data;
        r_crc      <= 8'd0;
        r_wr_ptr   <= '0;
      end else if (w_data_byte) begin
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        r_crc      <= crc8_d8(rx_data, r_crc);
        r_byte_cnt <= r_byte_cnt - 8'd1;
      end
      if (w_accept) begin
        r_buffer_valid <= 1'b1;
        r_buffer_len   <= r_len;
      end else if (w_ack) begin
        r_buffer_valid <= 1'b0;
      end
      if (w_ack)              r_overrun <= 1'b0;
      else if (w_overrun_set) r_overrun <= 1'b1;
    end
  end

  s3g_rx_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (rx_data),
    .rd_addr (buffer_addr),
    .rd_data (buffer_data)
  );

  assign buffer_len   = r_buffer_len;
  assign buffer_valid = r_buffer_valid;
  assign packet_done  = r_done;
  assign packet_error = r_error;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_s3g_rx_pkt.sv
module tb_s3g_rx_pkt;
  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam logic [7:0] SB = 8'hD5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_done = 1'b0;
  logic [ADDR_W-1:0] buffer_addr = '0;
  logic [7:0]        buffer_data, buffer_len;
  logic              buffer_valid, packet_ack = 1'b0, packet_done, packet_error, overrun;

  s3g_rx_pkt #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .START_BYTE(SB), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data), .buffer_len(buffer_len),
    .buffer_valid(buffer_valid), .packet_ack(packet_ack), .packet_done(packet_done),
    .packet_error(packet_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0;

  // Reference model of the host-visible state.
  int         exp_done = 0, exp_err = 0;
  logic       exp_valid = 1'b0, exp_overrun = 1'b0;
  logic [7:0] exp_len = 8'd0;
  logic [7:0] exp_buf [$];

  always @(negedge clk) begin
    if (packet_done)  done_cnt++;
    if (packet_error) err_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC8, LSB first, reflected poly 0x8C.
  function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
    logic [7:0] c = 8'd0;
    logic fb;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic do_ack();
    @(posedge clk); #1 packet_ack = 1'b1;
    @(posedge clk); #1 packet_ack = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_overrun = 1'b0;
    end
    chk("ack_valid", buffer_valid, exp_valid);
    chk("ack_overrun", overrun, exp_overrun);
  endtask

  task automatic check_state(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_valid"}, buffer_valid, exp_valid);
    chk({tag, "_overrun"}, overrun, exp_overrun);
    chk({tag, "_len"}, buffer_len, exp_len);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    if (exp_valid) begin
      for (int i = 0; i < exp_len; i++) begin
        @(posedge clk); #1 buffer_addr = ADDR_W'(i);
        @(posedge clk); #1;
        chk({tag, "_data"}, buffer_data, exp_buf[i]);
      end
    end
  endtask

  // Full packet; corrupt!=0 flips CRC bits.
  task automatic do_packet(input int len, input logic [7:0] corrupt);
    logic [7:0] pl[$];
    logic [7:0] pkt[$];
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
    pkt = {SB, 8'(len)};
    foreach (pl[i]) pkt.push_back(pl[i]);
    pkt.push_back(ref_crc(pl) ^ corrupt);
    send_q(pkt);
    if (exp_valid) exp_overrun = 1'b1;
    else if (corrupt == 8'd0) begin
      exp_done++;
      exp_valid = 1'b1;
      exp_len = 8'(len);
      exp_buf = pl;
    end else exp_err++;
  endtask

  task automatic do_badlen(input logic [7:0] len);
    logic [7:0] g;
    send_byte(SB);
    send_byte(len);
    if (exp_valid) exp_overrun = 1'b1;
    else exp_err++;
    repeat ($urandom_range(0, 3)) begin
      g = 8'($urandom_range(0, 255));
      if (g == SB) g = 8'h00;
      send_byte(g);
    end
  endtask

  task automatic do_collide();
    @(posedge clk); #1;
    rx_data = SB; rx_done = 1'b1; packet_ack = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; packet_ack = 1'b0;
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    chk("collide_valid", buffer_valid, 1'b0);
    chk("collide_overrun", overrun, 1'b0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    exp_done++;
    exp_valid = 1'b1;
    exp_len = 8'd1;
    exp_buf = {8'h00};
  endtask

  task automatic do_reset_mid();
    send_q({SB, 8'h03, 8'h11});
    if (exp_valid) exp_overrun = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", buffer_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_len", buffer_len, 8'd0);
    chk("rst_data", buffer_data, 8'd0);
    chk("rst_done", packet_done, 1'b0);
    chk("rst_err", packet_error, 1'b0);
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    exp_len = 8'd0;
  endtask

  initial begin
    int sel;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", buffer_valid, 1'b0);
    chk("reset_len", buffer_len, 8'd0);
    chk("reset_data", buffer_data, 8'd0);
    chk("reset_done", packet_done, 1'b0);
    chk("reset_err", packet_error, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    rst = 1'b0;

    // 1: good single-byte packet, pulse seen right after the CRC byte.
    send_q({SB, 8'h01, 8'h01, 8'h5E});
    chk("t1_done_pulse", packet_done, 1'b1);
    chk("t1_valid", buffer_valid, 1'b1);
    exp_done++; exp_valid = 1'b1; exp_len = 8'd1; exp_buf = {8'h01};
    check_state("t1");

    // 4: overrun while held, buffer untouched, then ack.
    send_q({SB, 8'h01, 8'h02, 8'h33});
    exp_overrun = 1'b1;
    check_state("t4");
    do_ack();

    // 2: bad CRC then a good packet.
    send_q({SB, 8'h02, 8'h00, 8'h00, 8'hFF});
    chk("t2_err_pulse", packet_error, 1'b1);
    exp_err++;
    check_state("t2a");
    send_q({SB, 8'h01, 8'h00, 8'h00});
    exp_done++; exp_valid = 1'b1; exp_len = 8'd1; exp_buf = {8'h00};
    check_state("t2b");
    do_ack();

    // 3: length errors at both boundaries, trailing bytes ignored.
    send_q({SB, 8'h00, 8'h01, 8'h5E});
    exp_err++;
    check_state("t3a");
    send_q({SB, 8'h21, 8'h01, 8'h5E});
    exp_err++;
    check_state("t3b");
    do_packet(MAX_LEN, 8'h00);
    check_state("t3_maxlen");

    // 5: ack and START in the same cycle.
    do_collide();
    check_state("t5");

`ifdef S3G_RX_TIMEOUT_EN
    do_ack();
    send_q({SB, 8'h03, 8'h11});
    repeat (105) @(posedge clk);
    exp_err++;
    check_state("t6_timeout");
`endif

    do_reset_mid();
    check_state("t6_rst");

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: do_packet($urandom_range(1, MAX_LEN), 8'h00);
        3:       do_packet($urandom_range(1, MAX_LEN), 8'($urandom_range(1, 255)));
        4:       do_badlen(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        5, 6:    do_ack();
        7:       if (exp_valid) do_collide(); else do_packet($urandom_range(1, MAX_LEN), 8'h00);
        8:       do_reset_mid();
        default: do_packet($urandom_range(1, 4), 8'h00);
      endcase
      check_state("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
